uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
Command-layer stage directly downstream of the UART byte link (uart_comm). It pops received bytes from the link's receive FIFO and parses fixed-format read/write frames. Each valid frame is turned into a single 32-bit memory request (program loading, debug peek and poke). Replies go back through the link's send FIFO.

Parameters:
TIMEOUT_CYCLES, 8000000, maximum idle cycles between bytes inside a frame (0.1 s at 80 MHz) before the frame is abandoned.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-low reset.
recv_flag  out  1  one-cycle pop strobe to the link receive FIFO.
recv_data  in  8  head byte of the receive FIFO; valid while receivable=1.
receivable  in  1  receive FIFO non-empty.
send_flag  out  1  one-cycle push strobe to the link send FIFO.
send_data  out  8  byte pushed; valid with send_flag.
sendable  in  1  send FIFO not full.
mem_req  out  1  memory request; held until mem_ack.
mem_we  out  1  1=write, 0=read; stable while mem_req=1.
mem_addr  out  32  byte address; stable while mem_req=1.
mem_wdata  out  32  write data; stable while mem_req=1.
mem_ack  in  1  one-cycle completion pulse.
mem_rdata  in  32  read data; valid in the mem_ack cycle.
busy  out  1  high in every state except IDLE.
err_count  out  8  saturating error counter (stops at 255).

Behaviour:
- Frame format:
  - Byte 0: opcode, 0x57 = write, 0x52 = read.
  - Bytes 1-4: address, little-endian.
  - Bytes 5-8: data, little-endian; present for writes only.
  - Last byte: checksum, the XOR of all preceding bytes in the frame.
- Reset (RST=0, asynchronous):
  - State returns to IDLE; all strobes, mem_req, mem_we, busy, err_count, mem_addr, mem_wdata and send_data go to 0.
  - Reset mid-frame or mid-request aborts it; mem_req drops immediately.
- Pop rule:
  - When receivable=1 in a byte-consuming state: capture recv_data and pulse recv_flag for 1 cycle.
  - The next cycle pops nothing, so at most one pop every 2 cycles and the FIFO flags can settle.
- State machine:
  - IDLE: pop a byte. 0x57 or 0x52 goes to ADDR. Any other byte is discarded, err_count+1, no reply, stay in IDLE.
  - ADDR: after 4 bytes, go to DATA for writes or CSUM for reads.
  - DATA: after 4 bytes, go to CSUM.
  - CSUM: pop 1 byte and compare it with the running XOR.
    - Match: go to MEM.
    - Mismatch: queue NAK 0x15, err_count+1, go to REPLY. No memory access is issued.
  - MEM: mem_req=1 from the cycle after entry until the cycle mem_ack=1 is sampled, then deassert.
    - Write: queue ACK 0x06.
    - Read: queue 0x06, then mem_rdata bytes LSB first, then the XOR of those 4 bytes (6 bytes total).
    - Go to REPLY.
  - REPLY: push queued bytes in order.
    - A push happens only in a cycle with sendable=1, followed by 1 idle cycle.
    - While sendable=0, nothing is dropped or reordered.
    - After the last byte, go to IDLE.
- Timeout:
  - An inter-byte counter runs in ADDR, DATA and CSUM and clears on every pop.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, err_count+1, no reply, the partial frame is discarded.
  - No timeout applies in MEM or REPLY, which wait indefinitely.
- Receive bytes arriving during MEM or REPLY stay in the link FIFO, unpopped, until IDLE.
- Simultaneous events: a timeout and a pop in the same cycle resolve in favour of the pop.
- Error-count saturation: err_count increments are ignored at 255.
- Latency: last checksum byte popped to mem_req high = 2 cycles; mem_ack to first send_flag = 2 cycles when sendable=1.

Decomposition:
- Package uart_cmd_pkg:
  - Opcode constants OP_WRITE=0x57 and OP_READ=0x52.
  - Reply constants ACK=0x06 and NAK=0x15.
  - State encoding IDLE/ADDR/DATA/CSUM/MEM/REPLY.
- Sub-module uart_cmd_reply: a 6-byte reply buffer with length, a read index and pacing against sendable, driving send_flag and send_data.

Test Plan:
- Write frame 57 00 10 00 00 EF BE AD DE 65 -> mem_req with mem_we=1, mem_addr=0x00001000, mem_wdata=0xDEADBEEF; after mem_ack, exactly one push of 0x06.
- Read frame 52 04 10 00 00 46, with mem_rdata=0x12345678 on ack -> mem_we=0, mem_addr=0x00001004; pushes 06 78 56 34 12 08 in order.
- Write frame as above but checksum 00 -> no mem_req, push 0x15, err_count=1.
- Byte 41 followed by a valid read frame -> 41 discarded with no reply, err_count=1; the read completes normally.
- Bytes 57 00 then silence for TIMEOUT_CYCLES (set to 100) -> busy falls, err_count=1, no push; the next full write frame is accepted.
- Read frame with sendable=0 for 50 cycles during REPLY -> no send_flag while low; all 6 bytes delivered correctly and in order afterwards.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command decoder.
package uart_cmd_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam int         REPLY_MAX = 6;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, CSUM, MEM, REPLY
  } state_e;
endpackage

// File: rtl/uart_cmd_reply.sv
// Reply buffer: holds up to six bytes and drains them into the link send FIFO,
// one push at most every other cycle and only while the FIFO has room.
module uart_cmd_reply
  import uart_cmd_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          load,
  input  logic [2:0]                    load_len,
  input  logic [REPLY_MAX-1:0][7:0]     load_bytes,
  input  logic                          sendable,
  output logic                          send_flag,
  output logic [7:0]                    send_data,
  output logic                          active
);
  logic [REPLY_MAX-1:0][7:0] buf_q, buf_d;
  logic [2:0]                len_q, len_d, idx_q, idx_d;
  logic                      active_q, active_d, gap_q, gap_d;

  // Push decision looks at sendable in the same cycle so a full FIFO is never written.
  assign send_flag = active_q && !gap_q && sendable;
  assign send_data = send_flag ? buf_q[idx_q] : 8'h00;
  assign active    = active_q;

  always_comb begin
    buf_d    = buf_q;
    len_d    = len_q;
    idx_d    = idx_q;
    active_d = active_q;
    gap_d    = 1'b0;
    if (load) begin
      buf_d    = load_bytes;
      len_d    = load_len;
      idx_d    = 3'd0;
      active_d = 1'b1;
      gap_d    = 1'b1;
    end else if (send_flag) begin
      idx_d = idx_q + 3'd1;
      gap_d = 1'b1;
      if (idx_q + 3'd1 == len_q) active_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_q    <= '0;
      len_q    <= 3'd0;
      idx_q    <= 3'd0;
      active_q <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      gap_q    <= gap_d;
    end
  end
endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses read/write frames popped from the UART receive FIFO into single 32-bit
// memory requests and queues ACK/NAK/read-data replies back to the link.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8000000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        recv_flag,
  input  logic [7:0]  recv_data,
  input  logic        receivable,
  output logic        send_flag,
  output logic [7:0]  send_data,
  input  logic        sendable,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [7:0]  err_count
);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d, mem_req_q, mem_req_d, recv_flag_q, recv_flag_d, busy_q, busy_d;
  logic [7:0]  csum_q, csum_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, tmo_q, tmo_d;

  logic                      in_frame, can_pop, err_inc, reply_load, reply_active;
  logic [2:0]                reply_len;
  logic [REPLY_MAX-1:0][7:0] reply_bytes;
  logic [7:0]                rsum;

  assign in_frame  = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);
  // recv_flag_q doubles as the hold-off so the FIFO head settles between pops.
  assign can_pop   = (in_frame || state_q == IDLE) && receivable && !recv_flag_q;
  assign rsum      = mem_rdata[31:24] ^ mem_rdata[23:16] ^ mem_rdata[15:8] ^ mem_rdata[7:0];

  assign recv_flag = recv_flag_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign err_count = err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    csum_d      = csum_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_req_d   = mem_req_q;
    recv_flag_d = can_pop;
    tmo_d       = (in_frame && !can_pop) ? tmo_q + 32'd1 : 32'd0;
    err_inc     = 1'b0;
    reply_load  = 1'b0;
    reply_len   = 3'd1;
    reply_bytes = {40'h0, ACK};
    case (state_q)
      IDLE: if (can_pop) begin
        if (recv_data == OP_WRITE || recv_data == OP_READ) begin
          state_d = ADDR;
          wr_d    = (recv_data == OP_WRITE);
          csum_d  = recv_data;
          cnt_d   = 2'd0;
        end else begin
          err_inc = 1'b1;
        end
      end
      ADDR, DATA: if (can_pop) begin
        csum_d = csum_q ^ recv_data;
        cnt_d  = cnt_q + 2'd1;
        // Little-endian fields: shift new bytes in from the top.
        if (state_q == ADDR) addr_d  = {recv_data, addr_q[31:8]};
        else                 wdata_d = {recv_data, wdata_q[31:8]};
        if (cnt_q == 2'd3) state_d = (state_q == ADDR && wr_q) ? DATA : CSUM;
      end
      CSUM: if (can_pop) begin
        if (recv_data == csum_q) begin
          state_d = MEM;
        end else begin
          reply_load  = 1'b1;
          reply_bytes = {40'h0, NAK};
          err_inc     = 1'b1;
          state_d     = REPLY;
        end
      end
      MEM: begin
        if (mem_req_q && mem_ack) begin
          mem_req_d  = 1'b0;
          reply_load = 1'b1;
          state_d    = REPLY;
          if (!wr_q) begin
            reply_len   = 3'd6;
            reply_bytes = {rsum, mem_rdata, ACK};
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      REPLY: if (!reply_active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A pop in the same cycle keeps the frame alive.
    if (in_frame && !can_pop && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_inc = 1'b1;
      tmo_d   = 32'd0;
    end
    err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      wr_q        <= 1'b0;
      csum_q      <= 8'h00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      tmo_q       <= 32'h0;
      err_q       <= 8'h00;
      mem_req_q   <= 1'b0;
      recv_flag_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      recv_flag_q <= recv_flag_d;
      busy_q      <= busy_d;
    end
  end

  uart_cmd_reply u_reply (
    .CLK        (CLK),
    .RST        (RST),
    .load       (reply_load),
    .load_len   (reply_len),
    .load_bytes (reply_bytes),
    .sendable   (sendable),
    .send_flag  (send_flag),
    .send_data  (send_data),
    .active     (reply_active)
  );
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: frame builder pushes expected requests/replies, monitor pops and compares.
module tb_uart_cmd_decoder;
  localparam int TMO = 100;

  logic        CLK = 1'b0, RST = 1'b0;
  logic        recv_flag, receivable = 1'b0, send_flag, sendable = 1'b1;
  logic [7:0]  recv_data = 8'h00, send_data, err_count;
  logic        mem_req, mem_we, mem_ack = 1'b0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;

  always #5 CLK = ~CLK;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .recv_flag(recv_flag), .recv_data(recv_data),
    .receivable(receivable), .send_flag(send_flag), .send_data(send_data),
    .sendable(sendable), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err_count(err_count)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  req_t        exp_mem[$];
  logic [7:0]  exp_tx[$], host_q[$], rx_q[$];
  logic [31:0] rd_q[$];
  int          n_chk = 0, n_pass = 0, exp_err = 0, snd_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic err_bump();
    if (exp_err < 255) exp_err++;
  endtask

  // Reference: frame bytes and replies built directly from the frame rules.
  task automatic frame(input bit wr, input logic [31:0] a, d, rd, input bit bad);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) b.push_back(a[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) b.push_back(d[8*i +: 8]);
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    if (bad) x ^= 8'($urandom_range(1, 255));
    b.push_back(x);
    if (bad) begin
      exp_tx.push_back(8'h15);
      err_bump();
    end else begin
      exp_mem.push_back('{we: wr, addr: a, wdata: d});
      rd_q.push_back(rd);
      exp_tx.push_back(8'h06);
      if (!wr) begin
        for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
        exp_tx.push_back(rd[7:0] ^ rd[15:8] ^ rd[23:16] ^ rd[31:24]);
      end
    end
    foreach (b[i]) host_q.push_back(b[i]);
  endtask

  task automatic junk();
    logic [7:0] j;
    do j = 8'($urandom); while (j == 8'h57 || j == 8'h52);
    host_q.push_back(j);
    err_bump();
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n = 0;
    do begin @(negedge CLK); #1; n++; end
    while (!(host_q.size() == 0 && rx_q.size() == 0 && !busy && exp_tx.size() == 0 &&
             exp_mem.size() == 0) && n < bound);
    chk(nm, n < bound, 1'b1);
  endtask

  // Link receive FIFO model.
  initial forever begin
    @(negedge CLK);
    if (recv_flag && rx_q.size() > 0) void'(rx_q.pop_front());
    if (host_q.size() > 0 && $urandom_range(0, 1) == 1) rx_q.push_back(host_q.pop_front());
    receivable = rx_q.size() > 0;
    recv_data  = receivable ? rx_q[0] : 8'h00;
  end

  initial forever begin
    @(negedge CLK);
    sendable = (snd_mode == 0) ? 1'b1 : (snd_mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
  end

  // Memory responder with random latency.
  initial begin
    int dly = 0;
    forever begin
      @(negedge CLK);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (dly == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom();
          dly       = $urandom_range(0, 3);
        end else dly--;
      end
    end
  end

  // Monitor.
  initial begin
    bit   req_seen = 0;
    req_t cur, e;
    forever begin
      @(negedge CLK); #1;
      if (send_flag) begin
        chk("push_while_full", sendable, 1'b1);
        if (exp_tx.size() == 0) chk("tx_unexpected_qsize", exp_tx.size(), 1);
        else chk("tx_byte", send_data, exp_tx.pop_front());
      end
      if (mem_req && !req_seen) begin
        req_seen = 1;
        cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        if (exp_mem.size() == 0) chk("mem_unexpected_qsize", exp_mem.size(), 1);
        else begin
          e = exp_mem.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end else if (mem_req && (mem_we != cur.we || mem_addr != cur.addr || mem_wdata != cur.wdata))
        chk("mem_stable", {mem_we, mem_addr, mem_wdata}, {cur.we, cur.addr, cur.wdata});
      if (!mem_req) req_seen = 0;
      if (mem_req && recv_flag) chk("pop_during_mem", recv_flag, 1'b0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wf[10] = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h65};
    logic [7:0] rf[6]  = '{8'h52, 8'h04, 8'h10, 8'h00, 8'h00, 8'h46};
    logic [7:0] rexp[6] = '{8'h06, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    int n, cnt;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_recv_flag", recv_flag, 0);  chk("rst_send_flag", send_flag, 0);
    chk("rst_send_data", send_data, 0);  chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);        chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);  chk("rst_busy", busy, 0);
    chk("rst_err", err_count, 0);
    @(negedge CLK); RST = 1'b1;

    // Directed write from literal bytes.
    exp_mem.push_back('{we: 1'b1, addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF});
    rd_q.push_back(32'h0); exp_tx.push_back(8'h06);
    foreach (wf[i]) host_q.push_back(wf[i]);
    wait_idle(500, "write_idle"); chk("write_err", err_count, 0);

    // Directed read.
    exp_mem.push_back('{we: 1'b0, addr: 32'h0000_1004, wdata: 32'h0});
    rd_q.push_back(32'h1234_5678);
    foreach (rexp[i]) exp_tx.push_back(rexp[i]);
    foreach (rf[i]) host_q.push_back(rf[i]);
    wait_idle(500, "read_idle"); chk("read_err", err_count, 0);

    // Bad checksum.
    exp_tx.push_back(8'h15); err_bump();
    for (int i = 0; i < 9; i++) host_q.push_back(wf[i]);
    host_q.push_back(8'h00);
    wait_idle(500, "nak_idle"); chk("nak_err", err_count, exp_err);

    // Junk byte then valid read.
    host_q.push_back(8'h41); err_bump();
    frame(1'b0, 32'h0000_1004, 32'h0, $urandom(), 1'b0);
    wait_idle(500, "junk_idle"); chk("junk_err", err_count, exp_err);

    // Timeout mid-frame.
    host_q.push_back(8'h57); host_q.push_back(8'h00); err_bump();
    repeat (20) @(negedge CLK);
    #1 chk("tmo_busy_before", busy, 1);
    repeat (TMO + 10) @(negedge CLK);
    #1 chk("tmo_busy_after", busy, 0);
    chk("tmo_err", err_count, exp_err);
    frame(1'b1, $urandom(), $urandom(), $urandom(), 1'b0);
    wait_idle(500, "tmo_next_idle");

    // Backpressure during reply.
    snd_mode = 1;
    frame(1'b0, $urandom(), 32'h0, $urandom(), 1'b0);
    n = 0;
    while (!mem_ack && n < 300) begin @(negedge CLK); #1; n++; end
    chk("bp_ack_seen", mem_ack, 1);
    cnt = 0;
    repeat (50) begin @(negedge CLK); #1; if (send_flag) cnt++; end
    chk("bp_no_push", cnt, 0); chk("bp_busy", busy, 1);
    snd_mode = 0;
    wait_idle(500, "bp_idle");

    // Randomized traffic, back to back.
    snd_mode = 2;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 9);
      if (n == 0) junk();
      else frame(n[0], $urandom(), $urandom(), $urandom(), n == 1);
    end
    wait_idle(20000, "rand_idle");
    snd_mode = 0;
    chk("rand_err", err_count, exp_err);

    // Error counter saturation.
    for (int k = 0; k < 260; k++) junk();
    wait_idle(5000, "sat_idle"); chk("sat_err", err_count, 255);
    frame(1'b1, $urandom(), $urandom(), $urandom(), 1'b1);
    wait_idle(500, "sat_nak_idle"); chk("sat_err_hold", err_count, exp_err);

    // Reset mid-frame.
    host_q.push_back(8'h57); host_q.push_back(8'h00); host_q.push_back(8'h10);
    repeat (20) @(negedge CLK);
    RST = 1'b0;
    #1 chk("mid_rst_busy", busy, 0); chk("mid_rst_err", err_count, 0);
    exp_err = 0;
    repeat (2) @(negedge CLK); RST = 1'b1;
    frame(1'b1, $urandom(), $urandom(), $urandom(), 1'b0);
    wait_idle(500, "post_rst_idle"); chk("post_rst_err", err_count, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
